instruction_fetch_unit: RTL and testbench

- Fetch stage that sits directly upstream of the control unit and the register/immediate decode.
- Owns the program counter and runs a req/ack handshake to the instruction memory, which has variable latency.
- Holds the fetched instruction stable until decode accepts it, then advances the PC. The next PC is PC+4 or the redirect target, selected by PCSel.
- Presents the pre-sliced decode fields: opcode[5:0] = instr[6:1], funct3 = instr[14:12], funct7 = instr[30].

---
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs a req/ack handshake to a variable-latency
// instruction memory and holds each fetched word until decode accepts it.
module instruction_fetch_unit #(
  parameter int unsigned         XLEN      = 32,
  parameter logic [XLEN-1:0]     RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            id_ready,
  input  logic            PCSel,
  input  logic [XLEN-1:0] target,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [5:0]      opcode,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic            misaligned,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_req;
  logic            r_valid;
  logic            r_misaligned;
  logic [31:0]     r_fetch_count;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_unused_tgt0;

  // target[0] is dropped by jalr semantics; target[1] only raises misaligned
  assign w_pc_plus4    = r_pc + XLEN'(4);
  assign w_next_pc     = PCSel ? {target[XLEN-1:2], 2'b00} : w_pc_plus4;
  assign w_unused_tgt0 = target[0];

  // Fetch FSM: PCSel/target are only consulted on the HOLD hand-off edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_req         <= 1'b0;
      r_valid       <= 1'b0;
      r_misaligned  <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            r_instr       <= NOP_INSTR;
            r_valid       <= 1'b0;
            r_fetch_count <= r_fetch_count + 32'd1;
            r_pc          <= w_next_pc;
            r_misaligned  <= PCSel & target[1];
            r_req         <= 1'b1;
            r_state       <= S_REQ;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign opcode      = r_instr[6:1];
  assign funct3      = r_instr[14:12];
  assign funct7      = r_instr[30];
  assign misaligned  = r_misaligned;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, reset-abort
// sequence and random traffic against a transaction-level fetch model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_ready = 1'b0;
  logic        PCSel = 1'b0;
  logic [31:0] target = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [5:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;
  logic        misaligned;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .PCSel(PCSel), .target(target),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .misaligned(misaligned), .fetch_count(fetch_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: where we are in the fetch of the current PC
  bit          m_idle, m_hold, m_mis;
  logic [31:0] m_pc, m_count;

  logic [31:0] c_addr;
  logic        c_mis;
  logic [5:0]  c_opcode;
  logic [2:0]  c_funct3;

  typedef struct {
    int          waits;
    int          stall;
    logic        sel;
    logic [31:0] tgt;
    logic [31:0] exp_next;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at posedge+1; drives one cycle, checks at negedge, advances model
  task automatic run_cycle(input logic ack, input logic rdy, input logic sel, input logic [31:0] tgt);
    logic [31:0] exp_instr;
    imem_ack   = ack;
    id_ready   = rdy;
    PCSel      = sel;
    target     = tgt;
    imem_rdata = (!m_hold && !m_idle) ? mem_word(m_pc) : $urandom;
    @(negedge clk);
    exp_instr = m_hold ? mem_word(m_pc) : NOP;
    chk("imem_req",    32'(imem_req),    32'(!m_idle && !m_hold));
    chk("imem_addr",   imem_addr,        m_pc);
    chk("pc",          pc,               m_pc);
    chk("pc_plus4",    pc_plus4,         m_pc + 32'd4);
    chk("instr_valid", 32'(instr_valid), 32'(m_hold));
    chk("instr",       instr,            exp_instr);
    chk("opcode",      32'(opcode),      32'(exp_instr[6:1]));
    chk("funct3",      32'(funct3),      32'(exp_instr[14:12]));
    chk("funct7",      32'(funct7),      32'(exp_instr[30]));
    chk("misaligned",  32'(misaligned),  32'(m_mis));
    chk("fetch_count", fetch_count,      m_count);
    c_addr   = imem_addr;
    c_mis    = misaligned;
    c_opcode = opcode;
    c_funct3 = funct3;
    @(posedge clk);
    m_mis = 1'b0;
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (!m_hold) begin
      if (ack) m_hold = 1'b1;
    end else if (rdy) begin
      m_count = m_count + 32'd1;
      if (sel) begin
        m_pc  = {tgt[31:2], 2'b00};
        m_mis = tgt[1];
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_hold = 1'b0;
    end
    #1;
  endtask

  task automatic rand_cycles(input int n);
    logic ack, rdy;
    for (int k = 0; k < n; k++) begin
      if (!m_hold) begin
        ack = ($urandom_range(0, 2) == 0);
        rdy = 1'($urandom);
      end else begin
        ack = 1'($urandom);
        rdy = ($urandom_range(0, 2) != 0);
      end
      run_cycle(ack, rdy, 1'($urandom), $urandom);
    end
  endtask

  task automatic model_reset();
    m_idle  = 1'b1;
    m_hold  = 1'b0;
    m_mis   = 1'b0;
    m_pc    = 32'h0;
    m_count = 32'h0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"},    32'(imem_req),    32'd0);
    chk({tag, "_pc"},          pc,               32'h0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"},       instr,            NOP);
    chk({tag, "_misaligned"},  32'(misaligned),  32'd0);
    chk({tag, "_fetch_count"}, fetch_count,      32'h0);
  endtask

  initial begin
    tbl[0] = '{0, 0, 1'b0, 32'h0,         32'h0000_0004, 1'b0};
    tbl[1] = '{3, 0, 1'b0, 32'h0,         32'h0000_0008, 1'b0};
    tbl[2] = '{0, 5, 1'b1, 32'h0000_0103, 32'h0000_0100, 1'b1};
    tbl[3] = '{1, 0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0};
    tbl[4] = '{0, 0, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0};
    tbl[5] = '{2, 1, 1'b1, 32'h2000_0006, 32'h2000_0004, 1'b1};
    tbl[6] = '{0, 0, 1'b0, 32'hDEAD_BEEF, 32'h2000_0008, 1'b0};

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // IDLE cycle: a stray ack here must not be captured
    run_cycle(1'b1, 1'b1, 1'b1, 32'h5555_5555);

    for (int i = 0; i < 7; i++) begin
      for (int w = 0; w <= tbl[i].waits; w++) begin
        run_cycle(w == tbl[i].waits, 1'($urandom), 1'($urandom), $urandom);
        if (w == 0 && i == 0) chk("first_addr", c_addr, 32'h0);
        if (w == 0 && i > 0) begin
          chk("tbl_next_addr",  c_addr,     tbl[i-1].exp_next);
          chk("tbl_misaligned", 32'(c_mis), 32'(tbl[i-1].exp_mis));
        end
      end
      for (int s = 0; s < tbl[i].stall; s++)
        run_cycle(1'($urandom), 1'b0, 1'($urandom), $urandom);
      run_cycle(1'($urandom), 1'b1, tbl[i].sel, tbl[i].tgt);
      if (i == 0) begin
        chk("first_opcode", 32'(c_opcode), 32'(6'b001001));
        chk("first_funct3", 32'(c_funct3), 32'd0);
      end
    end
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("tbl_next_addr",  c_addr,     tbl[6].exp_next);
    chk("tbl_misaligned", 32'(c_mis), 32'(tbl[6].exp_mis));
    chk("tbl_count",      fetch_count, 32'd7);

    rand_cycles(500);

    // Abort an outstanding request with reset, acks during and after reset
    while (m_hold || m_idle) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_abort_req", 32'(imem_req), 32'd1);
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("abort_ack");
    rst_n = 1'b1;
    model_reset();
    run_cycle(1'b1, 1'b1, 1'b1, $urandom);

    rand_cycles(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
